// File: rtl/alarm_pkg.sv
// -----------------------------------------------------------------------------
// alarm_pkg
// Shared types and constants for the alarm clock time path.
//   state_t        : time_keeper load FSM encoding (RUN, CHECK, COMMIT)
//   bcd_time_t     : four BCD digits hh:mm. It is shared by the time register,
//                    the alarm register and the comparator.
//   MIN_MS_MAX, HOUR_MAX, DIGIT_MAX : BCD limits of a 24-hour clock
//   bcd_time_valid : true when a bcd_time_t holds a legal 00:00..23:59 time
// -----------------------------------------------------------------------------
package alarm_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_CHECK  = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  typedef struct packed {
    logic [3:0] hour_ms;
    logic [3:0] hour_ls;
    logic [3:0] min_ms;
    logic [3:0] min_ls;
  } bcd_time_t;

  localparam logic [3:0] DIGIT_MAX  = 4'd9;
  localparam logic [3:0] MIN_MS_MAX = 4'd5;
  localparam int         HOUR_MAX   = 23;

  // The last legal hour, split into its tens and units digits.
  localparam logic [3:0] HOUR_MAX_MS = 4'(HOUR_MAX / 10);
  localparam logic [3:0] HOUR_MAX_LS = 4'(HOUR_MAX % 10);

  function automatic logic bcd_time_valid(input bcd_time_t t);
    logic digits_ok;
    logic hour_ok;
    digits_ok = (t.hour_ms <= DIGIT_MAX) && (t.hour_ls <= DIGIT_MAX) &&
                (t.min_ms <= MIN_MS_MAX) && (t.min_ls <= DIGIT_MAX);
    hour_ok   = (t.hour_ms < HOUR_MAX_MS) ||
                ((t.hour_ms == HOUR_MAX_MS) && (t.hour_ls <= HOUR_MAX_LS));
    return digits_ok && hour_ok;
  endfunction

endpackage

// File: rtl/bcd_time_incr.sv
// -----------------------------------------------------------------------------
// bcd_time_incr
// Combinational incrementer that adds a number of minutes to a BCD time.
// The number of minutes is 0..9.
//   cur        in  bcd_time_t  current legal time
//   step       in  4           minutes to add (0..9)
//   nxt        out bcd_time_t  cur + step minutes, wrapped within 24 hours
//   hour_carry out 1           minutes wrapped past :59
//   day_carry  out 1           time wrapped 23:xx -> 00:xx
// A step of at most 9 minutes can cross the :59 boundary only once. The hour
// therefore advances by at most one.
// -----------------------------------------------------------------------------
module bcd_time_incr
  import alarm_pkg::*;
(
  input  bcd_time_t  cur,
  input  logic [3:0] step,
  output bcd_time_t  nxt,
  output logic       hour_carry,
  output logic       day_carry
);

  logic [4:0] ls_sum;
  logic       min_carry;

  always_comb begin
    nxt        = cur;
    hour_carry = 1'b0;
    day_carry  = 1'b0;
    min_carry  = 1'b0;

    // Minute units. The sum is at most 9 + 9 = 18, so one subtraction of 10 is enough.
    ls_sum = {1'b0, cur.min_ls} + {1'b0, step};
    if (ls_sum > {1'b0, DIGIT_MAX}) begin
      nxt.min_ls = 4'(ls_sum - 5'd10);
      min_carry  = 1'b1;
    end else begin
      nxt.min_ls = ls_sum[3:0];
    end

    // Minute tens: 5 -> 0 carries into the hour.
    if (min_carry) begin
      if (cur.min_ms >= MIN_MS_MAX) begin
        nxt.min_ms = 4'd0;
        hour_carry = 1'b1;
      end else begin
        nxt.min_ms = cur.min_ms + 4'd1;
      end
    end

    // Hours: 23 -> 00 ends the day. 09 -> 10 and 19 -> 20 carry into the tens digit.
    if (hour_carry) begin
      if ((cur.hour_ms == HOUR_MAX_MS) && (cur.hour_ls == HOUR_MAX_LS)) begin
        nxt.hour_ms = 4'd0;
        nxt.hour_ls = 4'd0;
        day_carry   = 1'b1;
      end else if (cur.hour_ls >= DIGIT_MAX) begin
        nxt.hour_ls = 4'd0;
        nxt.hour_ms = cur.hour_ms + 4'd1;
      end else begin
        nxt.hour_ls = cur.hour_ls + 4'd1;
      end
    end
  end

endmodule

// File: rtl/time_keeper.sv
// -----------------------------------------------------------------------------
// time_keeper
// Time-of-day register for the alarm clock. It holds BCD hh:mm in 24-hour format.
// The time advances on one_minute, or by FAST_STEP minutes per one_second while
// fast_set is high. A new time can be loaded through a valid/ready handshake.
// The load is checked before it is written.
// Parameters:
//   FAST_STEP   minutes per one_second during fast set (legal 1..9)
// Ports:
//   clock, reset                 clock, asynchronous active-high reset
//   one_second, one_minute       single-cycle timing pulses
//   fast_set                     level, selects the fast-set advance source
//   load_valid / load_ready      load handshake (ready only in RUN)
//   load_hour_ms..load_min_ls    BCD time to load
//   hour_ms..min_ls              current time, BCD, registered
//   hour_tick, day_tick          one-cycle rollover pulses (:59->:00, 23:59->00:00)
//   load_error                   one-cycle pulse when a load is rejected
// -----------------------------------------------------------------------------
module time_keeper
  import alarm_pkg::*;
#(
  parameter int unsigned FAST_STEP = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       one_second,
  input  logic       one_minute,
  input  logic       fast_set,
  input  logic       load_valid,
  output logic       load_ready,
  input  logic [3:0] load_hour_ms,
  input  logic [3:0] load_hour_ls,
  input  logic [3:0] load_min_ms,
  input  logic [3:0] load_min_ls,
  output logic [3:0] hour_ms,
  output logic [3:0] hour_ls,
  output logic [3:0] min_ms,
  output logic [3:0] min_ls,
  output logic       hour_tick,
  output logic       day_tick,
  output logic       load_error
);

  localparam logic [3:0] FAST_STEP_L = 4'(FAST_STEP);

  state_t     state;
  bcd_time_t  cur_time;
  bcd_time_t  shadow;
  logic       pending;
  logic [3:0] pend_step;

  logic       evt;
  logic [3:0] evt_step;
  logic       do_adv;
  logic [3:0] inc_step;
  bcd_time_t  inc_time;
  logic       inc_hour_carry;
  logic       inc_day_carry;

  // During fast set, one_minute is ignored. If a second and a minute pulse
  // arrive together, only the selected source counts, so they give one event.
  assign evt      = fast_set ? one_second : one_minute;
  assign evt_step = fast_set ? FAST_STEP_L : 4'd1;

  // In RUN, a live event and a deferred one merge into a single advance.
  // The live event sets the step size when both are present.
  assign do_adv   = (state == ST_RUN) && (evt || pending);
  assign inc_step = evt ? evt_step : pend_step;

  bcd_time_incr u_incr (
    .cur        (cur_time),
    .step       (inc_step),
    .nxt        (inc_time),
    .hour_carry (inc_hour_carry),
    .day_carry  (inc_day_carry)
  );

  assign load_ready = (state == ST_RUN);

  assign hour_ms = cur_time.hour_ms;
  assign hour_ls = cur_time.hour_ls;
  assign min_ms  = cur_time.min_ms;
  assign min_ls  = cur_time.min_ls;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= ST_RUN;
      cur_time   <= '0;
      shadow     <= '0;
      pending    <= 1'b0;
      pend_step  <= 4'd1;
      hour_tick  <= 1'b0;
      day_tick   <= 1'b0;
      load_error <= 1'b0;
    end else begin
      hour_tick  <= 1'b0;
      day_tick   <= 1'b0;
      load_error <= 1'b0;
      unique case (state)
        ST_RUN: begin
          if (do_adv) begin
            cur_time  <= inc_time;
            hour_tick <= inc_hour_carry;
            day_tick  <= inc_day_carry;
          end
          pending <= 1'b0;
          if (load_valid) begin
            shadow <= '{hour_ms: load_hour_ms, hour_ls: load_hour_ls,
                        min_ms:  load_min_ms,  min_ls:  load_min_ls};
            state  <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          // Events are held back until the load outcome is known.
          if (evt) begin
            pending   <= 1'b1;
            pend_step <= evt_step;
          end
          if (bcd_time_valid(shadow)) begin
            state <= ST_COMMIT;
          end else begin
            load_error <= 1'b1;
            state      <= ST_RUN;
          end
        end
        ST_COMMIT: begin
          // The loaded time replaces anything that happened during the load.
          cur_time <= shadow;
          pending  <= 1'b0;
          state    <= ST_RUN;
        end
        default: state <= ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_time_keeper.sv
module tb_time_keeper;

  logic       clock = 1'b0;
  logic       reset;
  logic       one_second, one_minute, fast_set, load_valid;
  logic       load_ready;
  logic [3:0] load_hour_ms, load_hour_ls, load_min_ms, load_min_ls;
  logic [3:0] hour_ms, hour_ls, min_ms, min_ls;
  logic       hour_tick, day_tick, load_error;

  logic [15:0] tnow;
  int checks   = 0;
  int failures = 0;
  int ht_cnt, dt_cnt;

  always #5 clock = ~clock;

  time_keeper #(.FAST_STEP(5)) dut (
    .clock        (clock),
    .reset        (reset),
    .one_second   (one_second),
    .one_minute   (one_minute),
    .fast_set     (fast_set),
    .load_valid   (load_valid),
    .load_ready   (load_ready),
    .load_hour_ms (load_hour_ms),
    .load_hour_ls (load_hour_ls),
    .load_min_ms  (load_min_ms),
    .load_min_ls  (load_min_ls),
    .hour_ms      (hour_ms),
    .hour_ls      (hour_ls),
    .min_ms       (min_ms),
    .min_ls       (min_ls),
    .hour_tick    (hour_tick),
    .day_tick     (day_tick),
    .load_error   (load_error)
  );

  assign tnow = {hour_ms, hour_ls, min_ms, min_ls};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Offers a load for one cycle; returns just after the handshake edge E0.
  task automatic offer(input logic [3:0] h1, input logic [3:0] h0,
                       input logic [3:0] m1, input logic [3:0] m0);
    load_hour_ms = h1; load_hour_ls = h0; load_min_ms = m1; load_min_ls = m0;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    one_second = 0; one_minute = 0; fast_set = 0; load_valid = 0;
    load_hour_ms = 0; load_hour_ls = 0; load_min_ms = 0; load_min_ls = 0;
    #1;
    check("rst_time", tnow, 16'h0000);
    check("rst_ready", load_ready, 1);
    check("rst_ticks", {hour_tick, day_tick, load_error}, 3'b000);
    @(negedge clock);
    reset = 1'b0;
    tick();

    // 60 minute pulses: 00:00 -> 01:00, one hour_tick on the last pulse.
    ht_cnt = 0; dt_cnt = 0;
    for (int i = 1; i <= 60; i++) begin
      one_minute = 1'b1;
      tick();
      one_minute = 1'b0;
      ht_cnt += int'(hour_tick);
      dt_cnt += int'(day_tick);
      if (i == 59) check("min59_time", tnow, 16'h0059);
      if (i == 60) check("min60_htick", hour_tick, 1);
    end
    check("min60_time", tnow, 16'h0100);
    check("min60_htick_count", ht_cnt, 1);
    check("min60_dtick_count", dt_cnt, 0);
    tick();
    check("htick_one_cycle", hour_tick, 0);

    // Valid load of 23:59, then the day rollover.
    offer(4'd2, 4'd3, 4'd5, 4'd9);
    check("load_busy_e0", load_ready, 0);
    tick();
    check("load_commit_err", load_error, 0);
    check("load_commit_busy", load_ready, 0);
    tick();
    check("load_2359_time", tnow, 16'h2359);
    check("load_2359_ready", load_ready, 1);
    one_minute = 1'b1;
    tick();
    one_minute = 1'b0;
    check("day_roll_time", tnow, 16'h0000);
    check("day_roll_ticks", {hour_tick, day_tick}, 2'b11);
    tick();
    check("day_roll_ticks_off", {hour_tick, day_tick}, 2'b00);

    // Rejected loads: hour 24, minute 60 and a digit of 0xA.
    offer(4'd2, 4'd4, 4'd0, 4'd0);
    tick();
    check("rej24_err", load_error, 1);
    check("rej24_ready", load_ready, 1);
    check("rej24_time", tnow, 16'h0000);
    tick();
    check("rej24_err_off", load_error, 0);
    offer(4'd0, 4'd1, 4'd6, 4'd0);
    tick();
    check("rej60_err", load_error, 1);
    check("rej60_time", tnow, 16'h0000);
    offer(4'd1, 4'hA, 4'd0, 4'd0);
    tick();
    check("rejA_err", load_error, 1);
    check("rejA_time", tnow, 16'h0000);

    // Valid load 12:34 with a minute arriving during CHECK: the load wins.
    offer(4'd1, 4'd2, 4'd3, 4'd4);
    one_minute = 1'b1;
    tick();
    one_minute = 1'b0;
    tick();
    check("load_1234_time", tnow, 16'h1234);
    tick();
    check("load_1234_no_pend", tnow, 16'h1234);

    // Invalid load with a minute arriving during CHECK: the deferred minute is applied.
    offer(4'd1, 4'd2, 4'd9, 4'd9);
    one_minute = 1'b1;
    tick();
    one_minute = 1'b0;
    check("rej_pend_err", load_error, 1);
    check("rej_pend_hold", tnow, 16'h1234);
    tick();
    check("rej_pend_time", tnow, 16'h1235);
    tick();
    check("rej_pend_once", tnow, 16'h1235);

    // Fast set with FAST_STEP = 5.
    offer(4'd1, 4'd0, 4'd5, 4'd7);
    tick();
    tick();
    check("load_1057", tnow, 16'h1057);
    fast_set = 1'b1;
    one_second = 1'b1;
    tick();
    one_second = 1'b0;
    check("fast_time", tnow, 16'h1102);
    check("fast_htick", hour_tick, 1);
    one_minute = 1'b1;
    tick();
    one_minute = 1'b0;
    check("fast_min_ignored", tnow, 16'h1102);
    check("fast_htick_off", hour_tick, 0);
    one_second = 1'b1; one_minute = 1'b1;
    tick();
    one_second = 1'b0; one_minute = 1'b0;
    check("fast_coincident", tnow, 16'h1107);
    fast_set = 1'b0;
    one_second = 1'b1; one_minute = 1'b1;
    tick();
    one_second = 1'b0; one_minute = 1'b0;
    check("norm_coincident", tnow, 16'h1108);

    // Reset right after the handshake aborts the load.
    offer(4'd0, 4'd5, 4'd0, 4'd5);
    reset = 1'b1;
    #1;
    check("abort_time_async", tnow, 16'h0000);
    check("abort_ready", load_ready, 1);
    @(negedge clock);
    reset = 1'b0;
    tick();
    tick();
    tick();
    check("abort_no_load", tnow, 16'h0000);
    check("abort_ready_after", load_ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/time_keeper.md
# time_keeper

Time-of-day register for the alarm clock. Consumes the single-cycle `one_minute` and `one_second` pulses from the timing generator and maintains the current time as BCD hours:minutes in 24-hour format. Accepts a validated time load through a valid/ready handshake, and supports fast-set advance. Drives the display and alarm-compare logic.

## Interface
Parameters:
- `FAST_STEP`, default 1: minutes advanced per `one_second` pulse while `fast_set` is high. Legal values are 1..9.

Ports:
- `clock`  in  1  single system clock, all state on rising edge
- `reset`  in  1  asynchronous, active-high; clears all state immediately
- `one_second`  in  1  single-cycle pulse, once per second
- `one_minute`  in  1  single-cycle pulse, once per minute
- `fast_set`  in  1  level; while high, minutes advance on `one_second` and `one_minute` is ignored
- `load_valid`  in  1  load request
- `load_ready`  out  1  high only in RUN state
- `load_hour_ms`, `load_hour_ls`, `load_min_ms`, `load_min_ls`  in  4 each  BCD time to load
- `hour_ms`, `hour_ls`, `min_ms`, `min_ls`  out  4 each  current time, BCD, registered
- `hour_tick`  out  1  one-cycle pulse on every minute 59→00 rollover
- `day_tick`  out  1  one-cycle pulse on the 23:59→00:00 rollover
- `load_error`  out  1  one-cycle pulse when a load is rejected

## Operation
- Reset values:
  - time 00:00 (all digits 0)
  - `hour_tick`, `day_tick`, `load_error` = 0
  - state RUN, so `load_ready` = 1
- Advance event:
  - In RUN: `one_minute` when `fast_set` = 0, or `one_second` when `fast_set` = 1.
  - Simultaneous `one_second` and `one_minute` count as one event.
- Increment rules:
  - `min_ls` 9→0 carries into `min_ms`.
  - `min_ms`:`min_ls` 59→00 carries into the hour and pulses `hour_tick`.
  - Hours 09→10 and 19→20 carry `hour_ls` into `hour_ms`.
  - 23→00 pulses `day_tick` in the same cycle as `hour_tick`.
- Fast set advances by `FAST_STEP` minutes with BCD carry. A carry past :59 wraps minutes modulo 60 and increments the hour exactly once.
- FSM states:
  - RUN: `load_ready` = 1. On `load_valid` && `load_ready`, capture the four load digits into shadow registers → CHECK.
  - CHECK: validity requires every digit ≤ 9, `min_ms` ≤ 5, and hour ≤ 23. Valid → COMMIT. Invalid → RUN, pulse `load_error`, leave time unchanged.
  - COMMIT: write shadow to time registers → RUN.
- Advance events during CHECK/COMMIT set a `pending` flag; multiple events collapse into one.
  - COMMIT clears `pending`; the loaded time wins.
  - A rejected load returns to RUN and applies `pending` as one advance in its first RUN cycle.
- `load_valid` outside RUN is ignored; no queuing.
- Outputs never show illegal BCD or out-of-range time.

## Timing
- Advance: event sampled at edge N; new time and any tick pulses visible after edge N (1-cycle latency). Pulses last exactly one cycle.
- Load, handshake at edge E0:
  - E1: CHECK decision.
  - Valid: new time visible after E2; `load_ready` high again after E2.
  - Invalid: `load_error` high for the cycle after E1; `load_ready` high after E1.
- Back-to-back loads: minimum 3 cycles apart when valid, 2 when invalid.
- `reset` asserted mid-load aborts the load. Shadow and `pending` are cleared; outputs return to reset values asynchronously. Operation resumes on the first edge after deassertion.

## Structure
- Shared package `alarm_pkg` holds:
  - FSM state encoding (RUN, CHECK, COMMIT)
  - BCD limit constants: `MIN_MS_MAX` = 5, `HOUR_MAX` = 23, digit max 9
  - `bcd_time_t` grouping of the four digits, reused by the alarm register and comparator
- One sub-module: `bcd_time_incr`, a combinational BCD time + n-minutes incrementer. It outputs the next four digits plus `hour_carry` and `day_carry`, and is shared by the normal and fast-set paths.

## Test plan
- Reset, then 60 `one_minute` pulses → 01:00; `hour_tick` pulses once on pulse 60; `day_tick` never pulses.
- Load 23:59 (valid), then one `one_minute` → 00:00 one cycle later; `hour_tick` and `day_tick` high in the same single cycle.
- Load hour 2,4 → `load_error` pulses one cycle after CHECK; time unchanged. Load min 6,0 → rejected the same way. Digit 0xA → rejected.
- Load 12:34 with a `one_minute` arriving during CHECK → time reads 12:34 after COMMIT, not 12:35. Same case with an invalid load → old time + 1 minute.
- `fast_set` = 1 with `FAST_STEP` = 5 from 10:57, one `one_second` → 11:02, `hour_tick` once. `one_minute` alone while `fast_set` = 1 → no change. Coincident second and minute pulses → a single step.
- Assert `reset` the cycle after load acceptance → outputs 00:00 immediately, `load_ready` = 1; the loaded value never appears.
